// File: rtl/enable_map_if.sv
// Signal bundle for enable_map: CPU bus, config switch and table write.
// Entry width grows by one write-protect bit when ENMAP_WP_EN is defined.
interface enable_map_if #(
    parameter int ADDR_W    = 16,
    parameter int PAGE_BITS = 4,
    parameter int CFG_W     = 2,
    parameter int N_CHAN    = 2
);
`ifdef ENMAP_WP_EN
    localparam int EW = N_CHAN + 1;
`else
    localparam int EW = N_CHAN;
`endif
    localparam int IDX_W = CFG_W + 2 + PAGE_BITS;

    logic [ADDR_W-1:0] address;
    logic              phi2;
    logic              rwbar;
    logic [N_CHAN-1:0] cs;
    logic              we;
    logic [CFG_W-1:0]  cfg_in;
    logic              cfg_req;
    logic              cfg_ack;
    logic [CFG_W-1:0]  cfg_active;
    logic              tbl_wr_en;
    logic [IDX_W-1:0]  tbl_wr_addr;
    logic [EW-1:0]     tbl_wr_data;
    logic              tbl_wr_ready;
    logic              wp_violation;
    logic              wp_clr;

    modport master (
        output address, phi2, rwbar, cfg_in, cfg_req,
        output tbl_wr_en, tbl_wr_addr, tbl_wr_data, wp_clr,
        input  cs, we, cfg_ack, cfg_active, tbl_wr_ready,
        input  wp_violation
    );

    modport slave (
        input  address, phi2, rwbar, cfg_in, cfg_req,
        input  tbl_wr_en, tbl_wr_addr, tbl_wr_data, wp_clr,
        output cs, we, cfg_ack, cfg_active, tbl_wr_ready,
        output wp_violation
    );
endinterface

// File: rtl/enable_map.sv
// Table-driven chip-select decoder for the romulator, with config switching
// on phi2 falls and a host write port. Optional write protect: ENMAP_WP_EN.
module enable_map #(
    parameter int ADDR_W    = 16,
    parameter int PAGE_BITS = 4,
    parameter int SUB_BIT   = 11,
    parameter int CFG_W     = 2,
    parameter int N_CHAN    = 2
) (
    input logic         fpga_clk,
    input logic         rst_n,
    enable_map_if.slave bus
);
`ifdef ENMAP_WP_EN
    localparam int EW = N_CHAN + 1;
`else
    localparam int EW = N_CHAN;
`endif
    localparam int IDX_W = CFG_W + 2 + PAGE_BITS;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {INIT, CAPTURE, RUN, PEND} state_t;

    state_t            state, state_nx;
    logic              s1, s, s_d;
    logic              fe;
    logic              run, capture, take_req, apply;
    logic [CFG_W-1:0]  cfg_pend;
    logic              hold_v;
    logic [IDX_W-1:0]  hold_addr;
    logic [EW-1:0]     hold_data;
    logic              accept, commit;
    logic [EW-1:0]     tbl [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [EW-1:0]     entry;
    logic              blk;
    logic              unused_in;

    // Bring phi2 into the fpga_clk domain and keep one stage of history.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= bus.phi2;
            s   <= s1;
            s_d <= s;
        end
    end

    assign fe = s_d & ~s;

    // State register.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nx;
    end

    // Next state: a request arriving with fe keeps us pending.
    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    state_nx = CAPTURE;
            CAPTURE: state_nx = RUN;
            RUN:     if (bus.cfg_req) state_nx = PEND;
            PEND:    if (fe && !bus.cfg_req) state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    // Per-state strobes for the datapath.
    always_comb begin
        run      = 1'b0;
        capture  = 1'b0;
        take_req = 1'b0;
        apply    = 1'b0;
        unique case (state)
            INIT:    ;
            CAPTURE: capture = 1'b1;
            RUN: begin
                run      = 1'b1;
                take_req = bus.cfg_req;
            end
            PEND: begin
                run      = 1'b1;
                take_req = bus.cfg_req;
                apply    = fe;
            end
            default: ;
        endcase
    end

    // Active/pending config; the old pending value wins over a same-cycle request.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cfg_active <= '0;
            cfg_pend       <= '0;
            bus.cfg_ack    <= 1'b0;
        end else begin
            bus.cfg_ack <= apply & ~bus.cfg_req;
            if (capture)    bus.cfg_active <= bus.cfg_in;
            else if (apply) bus.cfg_active <= cfg_pend;
            if (take_req)   cfg_pend <= bus.cfg_in;
        end
    end

    assign accept = bus.tbl_wr_en & bus.tbl_wr_ready;
    assign commit = hold_v & ~s;

    // One-entry holding register; it drains while the bus is idle.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tbl_wr_ready <= 1'b0;
            hold_v           <= 1'b0;
            hold_addr        <= '0;
            hold_data        <= '0;
        end else begin
            if (capture) bus.tbl_wr_ready <= 1'b1;
            if (accept) begin
                hold_v           <= 1'b1;
                hold_addr        <= bus.tbl_wr_addr;
                hold_data        <= bus.tbl_wr_data;
                bus.tbl_wr_ready <= 1'b0;
            end else if (commit) begin
                hold_v           <= 1'b0;
                bus.tbl_wr_ready <= 1'b1;
            end
        end
    end

    // Table storage survives reset.
    always_ff @(posedge fpga_clk) begin
        if (commit) tbl[hold_addr] <= hold_data;
    end

    // Decode straight from the phi2 pin so bus timing has no clock latency.
    always_comb begin
        idx   = {bus.cfg_active, bus.rwbar, bus.address[SUB_BIT],
                 bus.address[ADDR_W-1 -: PAGE_BITS]};
        entry = tbl[idx];
`ifdef ENMAP_WP_EN
        blk   = entry[N_CHAN] & ~bus.rwbar;
`else
        blk   = 1'b0;
`endif
        bus.cs = '0;
        bus.we = 1'b0;
        if (bus.phi2 && run && !blk) begin
            bus.cs = entry[N_CHAN-1:0];
            bus.we = ~bus.rwbar;
        end
    end

`ifdef ENMAP_WP_EN
    logic re;
    assign re = s & ~s_d;

    // Sticky protect hit; a new hit beats a same-cycle clear.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n)               bus.wp_violation <= 1'b0;
        else if (re && run && blk) bus.wp_violation <= 1'b1;
        else if (bus.wp_clr)       bus.wp_violation <= 1'b0;
    end

    assign unused_in = ^bus.address;
`else
    assign bus.wp_violation = 1'b0;
    assign unused_in = ^bus.address ^ bus.wp_clr;
`endif
endmodule

// File: tb/tb_enable_map.sv
// Randomised bench for enable_map with an event-level reference model.
// Build with ENMAP_WP_EN defined to also cover the write-protect path.
module tb_enable_map;
    localparam int ADDR_W    = 16;
    localparam int PAGE_BITS = 4;
    localparam int SUB_BIT   = 11;
    localparam int CFG_W     = 2;
    localparam int N_CHAN    = 2;
    localparam int IDX_W     = CFG_W + 2 + PAGE_BITS;
    localparam int DEPTH     = 1 << IDX_W;
`ifdef ENMAP_WP_EN
    localparam int EW = N_CHAN + 1;
`else
    localparam int EW = N_CHAN;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enable_map_if #(
        .ADDR_W(ADDR_W), .PAGE_BITS(PAGE_BITS),
        .CFG_W(CFG_W), .N_CHAN(N_CHAN)
    ) bus ();

    enable_map #(
        .ADDR_W(ADDR_W), .PAGE_BITS(PAGE_BITS), .SUB_BIT(SUB_BIT),
        .CFG_W(CFG_W), .N_CHAN(N_CHAN)
    ) dut (
        .fpga_clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phi2 sample history, startup count, pending config,
    // one held write and a copy of the table.
    bit [2:0]         mq;
    int               m_up;
    bit               m_pv;
    bit [CFG_W-1:0]   m_cfg, m_pend;
    bit               m_ack, m_ready, m_hold, m_wpv;
    bit [IDX_W-1:0]   m_ha;
    bit [EW-1:0]      m_hd;
    bit [EW-1:0]      m_tbl [DEPTH];

    function automatic void m_reset();
        mq = '0; m_up = 0; m_pv = 0; m_cfg = '0; m_pend = '0;
        m_ack = 0; m_ready = 0; m_hold = 0; m_wpv = 0;
    endfunction

    function automatic bit mprot(bit [EW-1:0] e);
        return (EW > N_CHAN) && e[EW-1];
    endfunction

    function automatic bit [IDX_W-1:0] m_idx();
        return {m_cfg, bus.rwbar, bus.address[SUB_BIT],
                bus.address[ADDR_W-1 -: PAGE_BITS]};
    endfunction

    always @(posedge clk) begin
        bit syn, fe_, re_, run_, rdy;
        bit [IDX_W-1:0] ix;
        if (!rst_n) m_reset();
        else begin
            syn  = mq[1];
            fe_  = mq[2] & ~mq[1];
            re_  = mq[1] & ~mq[2];
            run_ = (m_up == 2);
            rdy  = m_ready;
            ix   = m_idx();
            if (re_ && run_ && !bus.rwbar && mprot(m_tbl[ix])) m_wpv = 1;
            else if (bus.wp_clr) m_wpv = 0;
            m_ack = 0;
            if (m_up == 0) m_up = 1;
            else if (m_up == 1) begin
                m_cfg = bus.cfg_in; m_ready = 1; m_up = 2;
            end else begin
                if (m_pv && fe_) begin
                    m_cfg = m_pend; m_pv = 0; m_ack = !bus.cfg_req;
                end
                if (bus.cfg_req) begin m_pend = bus.cfg_in; m_pv = 1; end
            end
            if (rdy && bus.tbl_wr_en) begin
                m_hold = 1; m_ha = bus.tbl_wr_addr; m_hd = bus.tbl_wr_data;
                m_ready = 0;
            end else if (m_hold && !syn) begin
                m_tbl[m_ha] = m_hd; m_hold = 0; m_ready = 1;
            end
            mq = {mq[1:0], bus.phi2};
        end
    end

    // Every cycle: compare all outputs against the model.
    always @(negedge clk) begin
        bit [EW-1:0] e;
        bit ok, blk;
        #1;
        if (!rst_n) m_reset();
        e   = m_tbl[m_idx()];
        blk = mprot(e) && !bus.rwbar;
        ok  = bus.phi2 && (m_up == 2) && !blk;
        chk("cs", 32'(bus.cs), ok ? 32'(e[N_CHAN-1:0]) : 32'd0);
        chk("we", 32'(bus.we), 32'(ok && !bus.rwbar));
        chk("cfg_active", 32'(bus.cfg_active), 32'(m_cfg));
        chk("cfg_ack", 32'(bus.cfg_ack), 32'(m_ack));
        chk("tbl_wr_ready", 32'(bus.tbl_wr_ready), 32'(m_ready));
        chk("wp_violation", 32'(bus.wp_violation), 32'(m_wpv));
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.tbl_wr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ready_wait", 32'(bus.tbl_wr_ready), 32'd1);
    endtask

    task automatic put(input bit [IDX_W-1:0] a, input bit [EW-1:0] d);
        wait_ready();
        @(negedge clk);
        bus.tbl_wr_en = 1'b1; bus.tbl_wr_addr = a; bus.tbl_wr_data = d;
        @(negedge clk);
        bus.tbl_wr_en = 1'b0;
    endtask

    initial begin
        int hc;
        bus.address = '0; bus.phi2 = 1'b0; bus.rwbar = 1'b1;
        bus.cfg_in = '0; bus.cfg_req = 1'b0; bus.tbl_wr_en = 1'b0;
        bus.tbl_wr_addr = '0; bus.tbl_wr_data = '0; bus.wp_clr = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cs", 32'(bus.cs), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_cfg", 32'(bus.cfg_active), 32'd0);
        chk("rst_ready", 32'(bus.tbl_wr_ready), 32'd0);
        chk("rst_ack", 32'(bus.cfg_ack), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Load the whole table with phi2 idle.
        for (int i = 0; i < DEPTH; i++)
            put(IDX_W'(i), (i == 'h2C) ? EW'(2'b10) : EW'($urandom));
        wait_ready();

        // Read of cfg0 page C gates with phi2.
        @(negedge clk);
        bus.address = 16'hC000; bus.rwbar = 1'b1; bus.phi2 = 1'b1;
        #2;
        chk("t1_cs_hi", 32'(bus.cs), 32'h2);
        chk("t1_we", 32'(bus.we), 32'd0);
        @(negedge clk) bus.phi2 = 1'b0;
        #2 chk("t1_cs_lo", 32'(bus.cs), 32'd0);

        // Write while bus busy, then a dropped second write.
        @(negedge clk) bus.phi2 = 1'b1;
        repeat (4) @(negedge clk);
        bus.tbl_wr_en = 1'b1; bus.tbl_wr_addr = 8'h2C;
        bus.tbl_wr_data = EW'(2'b01);
        @(negedge clk) bus.tbl_wr_en = 1'b0;
        #2 chk("t4_ready_drop", 32'(bus.tbl_wr_ready), 32'd0);
        @(negedge clk);
        bus.tbl_wr_en = 1'b1; bus.tbl_wr_data = EW'(2'b11);
        @(negedge clk) bus.tbl_wr_en = 1'b0;
        repeat (3) @(negedge clk);
        #2 chk("t4_ready_held", 32'(bus.tbl_wr_ready), 32'd0);
        @(negedge clk) bus.phi2 = 1'b0;
        repeat (2) @(negedge clk);
        #2 chk("t4_ready_pre", 32'(bus.tbl_wr_ready), 32'd0);
        @(negedge clk);
        #2 chk("t4_ready_back", 32'(bus.tbl_wr_ready), 32'd1);
        @(negedge clk) bus.phi2 = 1'b1;
        #2 chk("t5_cs_first", 32'(bus.cs), 32'h1);

`ifdef ENMAP_WP_EN
        // Protected write access is blocked and flagged.
        @(negedge clk) bus.phi2 = 1'b0;
        put(8'h0C, EW'(3'b111));
        wait_ready();
        @(negedge clk);
        bus.rwbar = 1'b0; bus.phi2 = 1'b1;
        #2;
        chk("t6_cs", 32'(bus.cs), 32'd0);
        chk("t6_we", 32'(bus.we), 32'd0);
        repeat (3) @(negedge clk);
        #2 chk("t6_wp_set", 32'(bus.wp_violation), 32'd1);
        @(negedge clk);
        bus.phi2 = 1'b0; bus.wp_clr = 1'b1;
        @(negedge clk) bus.wp_clr = 1'b0;
        #2 chk("t6_wp_clr", 32'(bus.wp_violation), 32'd0);
        @(negedge clk);
        bus.rwbar = 1'b1; bus.phi2 = 1'b1;
`endif

        // Config switch lands three clocks after the phi2 fall.
        repeat (4) @(negedge clk);
        bus.cfg_in = 2'd1; bus.cfg_req = 1'b1;
        @(negedge clk) bus.cfg_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 chk("t3_wait", 32'(bus.cfg_active), 32'd0);
        @(negedge clk) bus.phi2 = 1'b0;
        @(negedge clk);
        #2 chk("t3_c1", 32'(bus.cfg_active), 32'd0);
        @(negedge clk);
        #2 chk("t3_c2", 32'(bus.cfg_active), 32'd0);
        @(negedge clk);
        #2;
        chk("t3_c3_cfg", 32'(bus.cfg_active), 32'd1);
        chk("t3_c3_ack", 32'(bus.cfg_ack), 32'd1);
        @(negedge clk);
        #2 chk("t3_ack_gone", 32'(bus.cfg_ack), 32'd0);

        // Reset while a switch is pending discards it.
        @(negedge clk) bus.phi2 = 1'b1;
        repeat (4) @(negedge clk);
        bus.cfg_in = 2'd3; bus.cfg_req = 1'b1;
        @(negedge clk) bus.cfg_req = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #2;
        chk("t2_cs_rst", 32'(bus.cs), 32'd0);
        chk("t2_cfg_rst", 32'(bus.cfg_active), 32'd0);
        @(negedge clk) bus.cfg_in = 2'd2;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 chk("t2_cfg_cap", 32'(bus.cfg_active), 32'd2);
        bus.phi2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #2 chk("t2_no_ack", 32'(bus.cfg_ack), 32'd0);
        end

        // Random traffic.
        hc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hc == 0) begin
                bus.phi2 = ~bus.phi2;
                hc = int'($urandom_range(1, 6));
            end else hc--;
            bus.address     = ADDR_W'($urandom);
            bus.rwbar       = 1'($urandom);
            bus.cfg_in      = CFG_W'($urandom);
            bus.cfg_req     = ($urandom_range(0, 7) == 0);
            bus.tbl_wr_en   = ($urandom_range(0, 3) == 0);
            bus.tbl_wr_addr = IDX_W'($urandom);
            bus.tbl_wr_data = EW'($urandom);
            bus.wp_clr      = ($urandom_range(0, 9) == 0);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
        end
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
